frenzy_input_ctrl: RTL and testbench

Player-input front end for the Frenzy core. It converts PS/2 key events from the HPS I/O block and the two MiSTer joystick words into registered per-player control lines. It also produces a frame-stretched coin pulse and the start lines. It sits between the HPS I/O block and the berzerk/Frenzy game core, and replaces the ad-hoc key latches in the top level.

---
 rtl/frenzy_input_pkg.sv | 45 ++++
 rtl/frenzy_coin_stretch.sv | 78 +++++++
 rtl/frenzy_input_ctrl.sv | 118 +++++++++++
 tb/tb_frenzy_input_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/frenzy_input_pkg.sv
// rtl/frenzy_input_pkg.sv - scan codes, joystick bit map and shared types for the Frenzy input front end
package frenzy_input_pkg;

    localparam logic [8:0] KEY_UP       = 9'h075;
    localparam logic [8:0] KEY_DOWN     = 9'h072;
    localparam logic [8:0] KEY_LEFT     = 9'h06B;
    localparam logic [8:0] KEY_RIGHT    = 9'h074;
    localparam logic [8:0] KEY_SPACE    = 9'h029;
    localparam logic [8:0] KEY_CTRL     = 9'h014;
    localparam logic [8:0] KEY_START1_A = 9'h005;
    localparam logic [8:0] KEY_START1_B = 9'h016;
    localparam logic [8:0] KEY_START2_A = 9'h006;
    localparam logic [8:0] KEY_START2_B = 9'h01E;
    localparam logic [8:0] KEY_COIN_A   = 9'h02E;
    localparam logic [8:0] KEY_COIN_B   = 9'h036;
    localparam logic [8:0] KEY_P2_UP    = 9'h02D;
    localparam logic [8:0] KEY_P2_DOWN  = 9'h02B;
    localparam logic [8:0] KEY_P2_LEFT  = 9'h023;
    localparam logic [8:0] KEY_P2_RIGHT = 9'h034;
    localparam logic [8:0] KEY_P2_FIRE  = 9'h01C;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;
    localparam int JOY_COIN   = 7;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        LOCK
    } coin_state_t;

    typedef struct packed {
        logic fire;
        logic up;
        logic down;
        logic left;
        logic right;
    } ctrl_t;

endpackage

// File: rtl/frenzy_coin_stretch.sv
// rtl/frenzy_coin_stretch.sv - coin request edge detect, vblank-counted pulse stretch and hold lockout
module frenzy_coin_stretch
    import frenzy_input_pkg::*;
#(
    parameter int COIN_FRAMES = 3
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic flush,
    input  logic req,
    input  logic vblank,
    output logic coin
);

    localparam logic [3:0] CNT_LOAD = 4'(COIN_FRAMES);

    coin_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        req_q;
    logic        vblank_q;
    logic        vb_rise;

    assign vb_rise = vblank & ~vblank_q;
    assign coin    = (state == ACTIVE);

    // req_q keeps sampling through flush so a request held across it cannot look like a new edge
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            req_q    <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            req_q    <= req;
            vblank_q <= vblank;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req && !req_q) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ACTIVE: begin
                if (vb_rise) begin
                    if (cnt <= 4'd1) begin
                        state_nxt = LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end
            LOCK: begin
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/frenzy_input_ctrl.sv
// rtl/frenzy_input_ctrl.sv - PS/2 key latches merged with joystick words into registered player controls
// Optional INPUT_P2_SPLIT_EN: each player takes only its own pad instead of both pads ORed.
module frenzy_input_ctrl
    import frenzy_input_pkg::*;
#(
    parameter int COIN_FRAMES = 3,
    parameter int JOY_BITS    = 16
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [10:0]         ps2_key,
    input  logic [JOY_BITS-1:0] joystick_0,
    input  logic [JOY_BITS-1:0] joystick_1,
    input  logic                vblank,
    input  logic                flush,
    output logic [4:0]          p1_ctrl,
    output logic [4:0]          p2_ctrl,
    output logic                start1,
    output logic                start2,
    output logic                coin
);

    logic       tgl_q;
    logic       key_event;
    logic       pressed;
    logic [8:0] code;
    ctrl_t      p1_key, p2_key;
    logic       start1_key, start2_key, coin_key;
    logic       coin_pad_q;
    logic       coin_req;
    ctrl_t      pad0, pad1, p1_pad, p2_pad;
    logic       unused_joy;

    assign key_event = ps2_key[10] ^ tgl_q;
    assign pressed   = ps2_key[9];
    assign code      = ps2_key[8:0];

    assign pad0 = '{fire: joystick_0[JOY_FIRE], up: joystick_0[JOY_UP], down: joystick_0[JOY_DOWN],
                    left: joystick_0[JOY_LEFT], right: joystick_0[JOY_RIGHT]};
    assign pad1 = '{fire: joystick_1[JOY_FIRE], up: joystick_1[JOY_UP], down: joystick_1[JOY_DOWN],
                    left: joystick_1[JOY_LEFT], right: joystick_1[JOY_RIGHT]};

`ifdef INPUT_P2_SPLIT_EN
    assign p1_pad = pad0;
    assign p2_pad = pad1;
`else
    assign p1_pad = pad0 | pad1;
    assign p2_pad = pad0 | pad1;
`endif

    assign unused_joy = ^{joystick_0[JOY_BITS-1:8], joystick_1[JOY_BITS-1:8]};

    // Arrow keys match on the low byte so both the extended and keypad variants steer player 1
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tgl_q      <= 1'b0;
            p1_key     <= '0;
            p2_key     <= '0;
            start1_key <= 1'b0;
            start2_key <= 1'b0;
            coin_key   <= 1'b0;
        end else if (flush) begin
            tgl_q      <= ps2_key[10];
            p1_key     <= '0;
            p2_key     <= '0;
            start1_key <= 1'b0;
            start2_key <= 1'b0;
            coin_key   <= 1'b0;
        end else begin
            tgl_q <= ps2_key[10];
            if (key_event) begin
                if (code[7:0] == KEY_UP[7:0])                        p1_key.up    <= pressed;
                else if (code[7:0] == KEY_DOWN[7:0])                 p1_key.down  <= pressed;
                else if (code[7:0] == KEY_LEFT[7:0])                 p1_key.left  <= pressed;
                else if (code[7:0] == KEY_RIGHT[7:0])                p1_key.right <= pressed;
                else if (code == KEY_SPACE || code == KEY_CTRL)      p1_key.fire  <= pressed;
                else if (code == KEY_START1_A || code == KEY_START1_B) start1_key <= pressed;
                else if (code == KEY_START2_A || code == KEY_START2_B) start2_key <= pressed;
                else if (code == KEY_COIN_A || code == KEY_COIN_B)   coin_key     <= pressed;
                else if (code == KEY_P2_UP)                          p2_key.up    <= pressed;
                else if (code == KEY_P2_DOWN)                        p2_key.down  <= pressed;
                else if (code == KEY_P2_LEFT)                        p2_key.left  <= pressed;
                else if (code == KEY_P2_RIGHT)                       p2_key.right <= pressed;
                else if (code == KEY_P2_FIRE)                        p2_key.fire  <= pressed;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1_ctrl    <= '0;
            p2_ctrl    <= '0;
            start1     <= 1'b0;
            start2     <= 1'b0;
            coin_pad_q <= 1'b0;
        end else begin
            p1_ctrl    <= p1_key | p1_pad;
            p2_ctrl    <= p2_key | p2_pad;
            start1     <= start1_key | joystick_0[JOY_START1] | joystick_1[JOY_START1];
            start2     <= start2_key | joystick_0[JOY_START2] | joystick_1[JOY_START2];
            coin_pad_q <= joystick_0[JOY_COIN] | joystick_1[JOY_COIN];
        end
    end

    assign coin_req = coin_key | coin_pad_q;

    frenzy_coin_stretch #(
        .COIN_FRAMES(COIN_FRAMES)
    ) u_coin_stretch (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .flush  (flush),
        .req    (coin_req),
        .vblank (vblank),
        .coin   (coin)
    );

endmodule

// File: tb/tb_frenzy_input_ctrl.sv
// tb/tb_frenzy_input_ctrl.sv - directed self-checking bench for frenzy_input_ctrl
module tb_frenzy_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        vblank;
    logic        flush;
    logic [4:0]  p1_ctrl;
    logic [4:0]  p2_ctrl;
    logic        start1;
    logic        start2;
    logic        coin;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    frenzy_input_ctrl #(
        .COIN_FRAMES(3),
        .JOY_BITS   (16)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .joystick_0(joystick_0),
        .joystick_1(joystick_1),
        .vblank    (vblank),
        .flush     (flush),
        .p1_ctrl   (p1_ctrl),
        .p2_ctrl   (p2_ctrl),
        .start1    (start1),
        .start2    (start2),
        .coin      (coin)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_key(input logic pr, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pr, code};
    endtask

    task automatic vb_pulse();
        vblank = 1'b1;
        tick(1);
        vblank = 1'b0;
        tick(2);
    endtask

    initial begin
        reset_n    = 1'b0;
        ps2_key    = 11'($urandom);
        joystick_0 = 16'($urandom);
        joystick_1 = 16'($urandom);
        vblank     = 1'($urandom);
        flush      = 1'($urandom);
        tick(3);
        check("rst_p1", 32'(p1_ctrl), 32'h0);
        check("rst_p2", 32'(p2_ctrl), 32'h0);
        check("rst_start", 32'({start1, start2}), 32'h0);
        check("rst_coin", 32'(coin), 32'h0);

        ps2_key    = '0;
        joystick_0 = '0;
        joystick_1 = '0;
        vblank     = 1'b0;
        flush      = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(3);
        check("idle_out", 32'({p1_ctrl, p2_ctrl, start1, start2, coin}), 32'h0);

        // keyboard latency and release
        send_key(1'b1, 9'h175);
        tick(1);
        check("up_lat1", 32'(p1_ctrl), 32'h00);
        tick(1);
        check("up_press", 32'(p1_ctrl), 32'h08);
        send_key(1'b0, 9'h175);
        tick(2);
        check("up_release", 32'(p1_ctrl), 32'h00);
        send_key(1'b1, 9'h099);
        tick(2);
        check("ignored_code", 32'({p1_ctrl, p2_ctrl, start1, start2, coin}), 32'h0);
        send_key(1'b1, 9'h029);
        tick(2);
        check("p1_fire_space", 32'(p1_ctrl), 32'h10);
        send_key(1'b0, 9'h029);
        tick(1);
        send_key(1'b1, 9'h016);
        tick(2);
        check("start1_key", 32'({start1, start2}), 32'h2);
        send_key(1'b0, 9'h016);
        tick(1);
        send_key(1'b1, 9'h034);
        tick(2);
        check("p2_right_key", 32'({p1_ctrl, p2_ctrl}), 32'h001);
        send_key(1'b0, 9'h034);
        tick(2);
        check("keys_clear", 32'({p1_ctrl, p2_ctrl, start1, start2}), 32'h0);

        // joystick merge
        joystick_1[0] = 1'b1;
        tick(1);
`ifdef INPUT_P2_SPLIT_EN
        check("joy1_right_p1", 32'(p1_ctrl), 32'h00);
`else
        check("joy1_right_p1", 32'(p1_ctrl), 32'h01);
`endif
        check("joy1_right_p2", 32'(p2_ctrl), 32'h01);
        joystick_1[0] = 1'b0;
        joystick_0[6] = 1'b1;
        tick(1);
        check("joy0_start2", 32'({start1, start2}), 32'h1);
        joystick_0[6] = 1'b0;
        tick(1);

        // coin key held for ten frames
        send_key(1'b1, 9'h02E);
        tick(1);
        check("coin_lat1", 32'(coin), 32'h0);
        tick(1);
        check("coin_on", 32'(coin), 32'h1);
        for (int f = 0; f < 10; f++) begin
            check($sformatf("coin_frame%0d", f), 32'(coin), (f < 3) ? 32'h1 : 32'h0);
            vb_pulse();
        end
        send_key(1'b0, 9'h02E);
        tick(2);
        check("coin_released", 32'(coin), 32'h0);
        send_key(1'b1, 9'h02E);
        tick(2);
        check("coin_repress", 32'(coin), 32'h1);
        repeat (3) vb_pulse();
        check("coin_repress_end", 32'(coin), 32'h0);
        send_key(1'b0, 9'h02E);
        tick(3);

        // pad coin with a vblank rise on the entry cycle, which must not count
        joystick_0[7] = 1'b1;
        tick(1);
        vblank = 1'b1;
        tick(1);
        check("pad_coin_on", 32'(coin), 32'h1);
        vblank = 1'b0;
        tick(1);
        vb_pulse();
        vb_pulse();
        check("pad_coin_2rise", 32'(coin), 32'h1);
        vb_pulse();
        check("pad_coin_3rise", 32'(coin), 32'h0);
        joystick_0[7] = 1'b0;
        tick(3);

        // flush clears latches and discards a simultaneous key event
        send_key(1'b1, 9'h01C);
        tick(2);
        check("p2_fire_key", 32'(p2_ctrl), 32'h10);
        flush = 1'b1;
        send_key(1'b1, 9'h175);
        tick(1);
        flush = 1'b0;
        tick(1);
        check("flush_p2", 32'(p2_ctrl), 32'h00);
        check("flush_p1_discard", 32'(p1_ctrl), 32'h00);
        tick(2);
        check("flush_no_late_event", 32'(p1_ctrl), 32'h00);

        // asynchronous reset mid-pulse with the coin key still held
        if (ps2_key[10] == 1'b0) begin
            send_key(1'b0, 9'h099);
            tick(1);
        end
        send_key(1'b1, 9'h02E);
        tick(2);
        check("coin_before_rst", 32'(coin), 32'h1);
        vb_pulse();
        check("coin_cnt2", 32'(coin), 32'h1);
        #2 reset_n = 1'b0;
        #1 check("coin_async_rst", 32'(coin), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check("held_after_rst", 32'(coin), 32'h0);
        vb_pulse();
        check("held_after_rst_vb", 32'(coin), 32'h0);
        send_key(1'b0, 9'h02E);
        tick(1);
        send_key(1'b1, 9'h02E);
        tick(2);
        check("repress_after_rst", 32'(coin), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
